// File: rtl/volume_fade_seq_pkg.sv
// volume_fade_pkg: shared states, response code, register offsets and the saturating gain step
package volume_fade_pkg;
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_WRITE, S_RESP, S_NEXT, S_CHECK} fade_state_t;
   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [3:0] ADDR_LEFT_DEF = 4'h0;
   localparam logic [3:0] ADDR_RIGHT_DEF = 4'h4;
   // Operands arrive zero-extended; one extra bit keeps the sum and the borrow visible.
   function automatic logic [31:0] next_vol(input logic [31:0] cur, input logic [31:0] tgt, input logic [31:0] stp);
      logic [32:0] up;
      logic [32:0] dn;
      up = {1'b0, cur} + {1'b0, stp};
      dn = {1'b0, cur} - {1'b0, stp};
      if (stp == 32'd0 || cur == tgt) return tgt;
      if (cur < tgt) return (up >= {1'b0, tgt}) ? tgt : up[31:0];
      return (dn[32] || dn <= {1'b0, tgt}) ? tgt : dn[31:0];
   endfunction
endpackage

// File: rtl/volume_fade_seq_if.sv
// volume_fade_seq_if: AXI4-Lite master bundle; AR/R exist only with VOLUME_FADE_READBACK_EN
interface volume_fade_seq_if #(parameter int AW = 4, parameter int DW = 32);
   logic [AW-1:0] awaddr;
   logic [2:0] awprot;
   logic awvalid, awready;
   logic [DW-1:0] wdata;
   logic [DW/8-1:0] wstrb;
   logic wvalid, wready;
   logic [1:0] bresp;
   logic bvalid, bready;
`ifdef VOLUME_FADE_READBACK_EN
   logic [AW-1:0] araddr;
   logic [2:0] arprot;
   logic arvalid, arready;
   logic [DW-1:0] rdata;
   logic [1:0] rresp;
   logic rvalid, rready;
   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
      input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
   modport slave (
      input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
`else
   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input awready, wready, bresp, bvalid
   );
   modport slave (
      input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output awready, wready, bresp, bvalid
   );
`endif
endinterface

// File: rtl/volume_fade_seq_axil_wr_beat.sv
// axil_wr_beat: one AXI4-Lite write; AW and W launch together and retire independently
module axil_wr_beat #(parameter int AW = 4, parameter int DW = 32) (
   input logic ACLK,
   input logic ARESET,
   input logic go,
   input logic [AW-1:0] addr,
   input logic [DW-1:0] data,
   volume_fade_seq_if.master m,
   output logic aw_w_done,
   output logic b_done,
   output logic [1:0] resp
);
   logic aw_v, w_v, b_w;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] data_q;
   assign m.awaddr = addr_q;
   assign m.awprot = 3'b000;
   assign m.awvalid = aw_v;
   assign m.wdata = data_q;
   assign m.wstrb = '1;
   assign m.wvalid = w_v;
   assign m.bready = b_w;
   assign aw_w_done = (aw_v || w_v) && (!aw_v || m.awready) && (!w_v || m.wready);
   assign b_done = b_w && m.bvalid;
   assign resp = m.bresp;
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         aw_v <= 1'b0;
         w_v <= 1'b0;
         b_w <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else if (go) begin
         aw_v <= 1'b1;
         w_v <= 1'b1;
         addr_q <= addr;
         data_q <= data;
      end else begin
         if (m.awready) aw_v <= 1'b0;
         if (m.wready) w_v <= 1'b0;
         if (aw_w_done) b_w <= 1'b1;
         else if (b_done) b_w <= 1'b0;
      end
   end
endmodule

// File: rtl/volume_fade_seq.sv
// volume_fade_seq: ramps left/right gain registers toward a target over AXI4-Lite, one step per interval
// VOLUME_FADE_READBACK_EN adds a read-back verification pass after the final step.
module volume_fade_seq import volume_fade_pkg::*; #(
   parameter int C_M_AXI_ADDR_WIDTH = 4,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int VOL_WIDTH = 16,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_LEFT = ADDR_LEFT_DEF,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_RIGHT = ADDR_RIGHT_DEF
) (
   input logic ACLK,
   input logic ARESET,
   input logic start,
   input logic [VOL_WIDTH-1:0] target_vol,
   input logic [VOL_WIDTH-1:0] step,
   input logic [15:0] interval,
   input logic [1:0] ch_en,
   output logic busy,
   output logic done,
   output logic err,
   output logic [VOL_WIDTH-1:0] cur_vol,
   volume_fade_seq_if.master m
);
   fade_state_t state, nxt;
   logic [VOL_WIDTH-1:0] tgt, stp, nv;
   logic [15:0] ival, cnt;
   logic [1:0] en;
   logic ch, go, go_ch, more, aw_w_done, b_done, r_last, rb_done, rb_err;
   logic [1:0] resp;
   assign nv = VOL_WIDTH'(next_vol(32'(cur_vol), 32'(tgt), 32'(stp)));
   assign more = !ch && en[1];
   assign busy = state != S_IDLE;
`ifdef VOLUME_FADE_READBACK_EN
   localparam bit RB = 1'b1;
   logic ar_v, r_w, rch;
   assign r_last = r_w && m.rvalid && !(!rch && en[1]);
   assign rb_done = r_last;
   assign rb_err = r_w && m.rvalid && (m.rresp != RESP_OKAY || m.rdata != C_M_AXI_DATA_WIDTH'(tgt));
   assign m.araddr = rch ? ADDR_RIGHT : ADDR_LEFT;
   assign m.arprot = 3'b000;
   assign m.arvalid = ar_v;
   assign m.rready = r_w;
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         ar_v <= 1'b0;
         r_w <= 1'b0;
         rch <= 1'b0;
      end else if (state == S_NEXT && nxt == S_CHECK) begin
         ar_v <= 1'b1;
         rch <= !en[0];
      end else if (ar_v && m.arready) begin
         ar_v <= 1'b0;
         r_w <= 1'b1;
      end else if (r_w && m.rvalid) begin
         r_w <= 1'b0;
         ar_v <= !r_last;
         rch <= rch || !r_last;
      end
   end
`else
   localparam bit RB = 1'b0;
   assign r_last = 1'b0;
   assign rb_done = 1'b0;
   assign rb_err = 1'b0;
`endif
   axil_wr_beat #(.AW(C_M_AXI_ADDR_WIDTH), .DW(C_M_AXI_DATA_WIDTH)) u_wr (
      .ACLK(ACLK),
      .ARESET(ARESET),
      .go(go),
      .addr(go_ch ? ADDR_RIGHT : ADDR_LEFT),
      .data(C_M_AXI_DATA_WIDTH'(nv)),
      .m(m),
      .aw_w_done(aw_w_done),
      .b_done(b_done),
      .resp(resp)
   );
   always_comb begin
      nxt = state;
      go = 1'b0;
      go_ch = ch;
      case (state)
         S_IDLE: nxt = (start && ch_en != 2'b00) ? S_WAIT : S_IDLE;
         S_WAIT: begin
            go = cnt == 16'd0;
            go_ch = !en[0];
            nxt = go ? S_WRITE : S_WAIT;
         end
         S_WRITE: nxt = aw_w_done ? S_RESP : S_WRITE;
         S_RESP: begin
            go = b_done && more;
            go_ch = 1'b1;
            nxt = !b_done ? S_RESP : more ? S_WRITE : S_NEXT;
         end
         S_NEXT: nxt = nv != tgt ? S_WAIT : RB ? S_CHECK : S_IDLE;
         S_CHECK: nxt = r_last ? S_IDLE : S_CHECK;
         default: nxt = S_IDLE;
      endcase
   end
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state <= S_IDLE;
         tgt <= '0;
         stp <= '0;
         ival <= '0;
         en <= '0;
         cnt <= '0;
         ch <= 1'b0;
         cur_vol <= '0;
         err <= 1'b0;
         done <= 1'b0;
      end else begin
         state <= nxt;
         done <= rb_done || (state == S_IDLE && start && ch_en == 2'b00) || (!RB && state == S_NEXT && nv == tgt);
         if (state == S_IDLE && start) begin
            tgt <= target_vol;
            stp <= step;
            ival <= interval;
            en <= ch_en;
            err <= 1'b0;
         end else if ((b_done && resp != RESP_OKAY) || rb_err) err <= 1'b1;
         if (state == S_IDLE && start) cnt <= interval;
         else if (state == S_NEXT) cnt <= ival;
         else if (state == S_WAIT && cnt != 16'd0) cnt <= cnt - 16'd1;
         if (go) ch <= go_ch;
         if (state == S_NEXT) cur_vol <= nv;
      end
   end
endmodule
